// File: rtl/priority_pkg.sv
// Shared types and helpers for the priority grant sequencer.
// Holds the default request width, the FSM state type and a one-hot to index helper.
package priority_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic {IDLE, GRANT} grant_state_t;

    // Returns the position of the highest set bit; callers pass a one-hot value.
    function automatic int onehot_to_idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/priority_encoder_n.sv
// Combinational highest-index-first priority encoder over the pending request set.
// Also reports whether any bit is set and whether exactly one bit is set.
module priority_encoder_n
    import priority_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  pending,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any,
    output logic          single
);

    logic [N-1:0] w_hi;

    // Later iterations overwrite earlier ones, so the MSB wins.
    always_comb begin
        w_hi = '0;
        for (int i = 0; i < N; i++) begin
            if (pending[i]) begin
                w_hi    = '0;
                w_hi[i] = 1'b1;
            end
        end
    end

    assign gnt     = w_hi;
    assign gnt_idx = IW'(onehot_to_idx(32'(w_hi)));
    assign any     = |pending;
    assign single  = any && ((pending & (pending - N'(1))) == '0);

endmodule

// File: rtl/priority_grant_sequencer.sv
// Latches one request vector per transaction and replays it as an ordered stream
// of one-hot grants, highest index first, over a valid/ready handshake.
module priority_grant_sequencer
    import priority_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic [N-1:0]  req,
    output logic          req_ready,
    output logic          gnt_valid,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_last,
    input  logic          gnt_ready,
    output logic          zero_req
);

    grant_state_t r_state;
    grant_state_t w_state_nxt;
    logic [N-1:0] r_pending;
    logic [N-1:0] w_pending_nxt;
    logic         r_zero_req;
    logic         w_zero_req_nxt;

    logic [N-1:0]  w_gnt;
    logic [IW-1:0] w_gnt_idx;
    logic          w_any;
    logic          w_single;

    priority_encoder_n #(
        .N  (N),
        .IW (IW)
    ) u_enc (
        .pending (r_pending),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any),
        .single  (w_single)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_zero_req <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_zero_req <= w_zero_req_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pending_nxt  = r_pending;
        w_zero_req_nxt = r_zero_req;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (req != '0) begin
                        w_pending_nxt = req;
                        w_state_nxt   = GRANT;
                    end else begin
                        w_zero_req_nxt = 1'b1;
                    end
                end
            end
            GRANT: begin
                if (gnt_ready && w_any) begin
                    if (w_single) begin
                        w_pending_nxt = '0;
                        w_state_nxt   = IDLE;
                    end else begin
                        w_pending_nxt = r_pending & ~w_gnt;
                    end
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

    // Outputs depend on registered state only; handshake inputs never reach them.
    assign req_ready = (r_state == IDLE);
    assign gnt_valid = (r_state == GRANT) && w_any;
    assign gnt       = gnt_valid ? w_gnt : '0;
    assign gnt_idx   = gnt_valid ? w_gnt_idx : '0;
    assign gnt_last  = gnt_valid && w_single;
    assign zero_req  = r_zero_req;

endmodule

// File: tb/tb_priority_grant_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase compared every cycle against a queue-based grant model.
module tb_priority_grant_sequencer;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic [N-1:0]  req = '0;
    logic          req_ready;
    logic          gnt_valid;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_last;
    logic          gnt_ready = 1'b0;
    logic          zero_req;

    int checks = 0;
    int errors = 0;

    // Model: remaining grant indices of the current batch, in service order.
    int m_q[$];
    bit m_zero = 1'b0;

    priority_grant_sequencer #(.N(N), .IW(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req       (req),
        .req_ready (req_ready),
        .gnt_valid (gnt_valid),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_last  (gnt_last),
        .gnt_ready (gnt_ready),
        .zero_req  (zero_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic e_ready, input logic e_valid,
                           input logic [N-1:0] e_gnt, input logic [IW-1:0] e_idx,
                           input logic e_last);
        chk({name, ".req_ready"}, 32'(req_ready), 32'(e_ready));
        chk({name, ".gnt_valid"}, 32'(gnt_valid), 32'(e_valid));
        chk({name, ".gnt"},       32'(gnt),       32'(e_gnt));
        chk({name, ".gnt_idx"},   32'(gnt_idx),   32'(e_idx));
        chk({name, ".gnt_last"},  32'(gnt_last),  32'(e_last));
    endtask

    // Reference model: accept in idle, then pop one index per grant handshake.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_q.delete();
                m_zero = 1'b0;
            end else if (m_q.size() == 0) begin
                if (req_valid) begin
                    if (req == '0) m_zero = 1'b1;
                    else begin
                        for (int i = N - 1; i >= 0; i--)
                            if (req[i]) m_q.push_back(i);
                    end
                end
            end else if (gnt_ready) begin
                void'(m_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        logic          busy;
        logic [IW-1:0] e_idx;
        busy  = (m_q.size() != 0);
        e_idx = busy ? IW'(m_q[0]) : '0;
        chk("model.req_ready", 32'(req_ready), 32'(!busy));
        chk("model.gnt_valid", 32'(gnt_valid), 32'(busy));
        chk("model.gnt",       32'(gnt),       busy ? (32'd1 << e_idx) : 32'd0);
        chk("model.gnt_idx",   32'(gnt_idx),   32'(e_idx));
        chk("model.gnt_last",  32'(gnt_last),  32'(busy && m_q.size() == 1));
        chk("model.zero_req",  32'(zero_req),  32'(m_zero));
    end

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_out("rst", 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
        chk("rst.zero_req", 32'(zero_req), 32'd0);

        // Scenario 1: 1011 with downstream always ready.
        req_valid = 1'b1; req = 4'b1011; gnt_ready = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        chk_out("t1.g0", 1'b0, 1'b1, 4'b1000, 2'd3, 1'b0);
        @(negedge clk);
        chk_out("t1.g1", 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0);
        @(negedge clk);
        chk_out("t1.g2", 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1);
        @(negedge clk);
        chk_out("t1.idle", 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);

        // Scenario 2: 0110 with grant back-pressure for three cycles.
        req_valid = 1'b1; req = 4'b0110; gnt_ready = 1'b0;
        @(negedge clk); req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_out("t2.hold", 1'b0, 1'b1, 4'b0100, 2'd2, 1'b0);
            if (k < 2) @(negedge clk);
        end
        gnt_ready = 1'b1;
        @(negedge clk);
        chk_out("t2.g1", 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1);
        @(negedge clk);
        chk_out("t2.idle", 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);

        // Scenario 3: all-zero vector is consumed and sets the sticky flag.
        req_valid = 1'b1; req = 4'b0000;
        @(negedge clk); req_valid = 1'b0;
        chk_out("t3.idle", 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
        chk("t3.zero_req", 32'(zero_req), 32'd1);

        // Scenario 5: a vector offered during GRANT waits for the batch to finish.
        req_valid = 1'b1; req = 4'b1100; gnt_ready = 1'b1;
        @(negedge clk); req = 4'b0011;
        chk_out("t5.g3", 1'b0, 1'b1, 4'b1000, 2'd3, 1'b0);
        @(negedge clk);
        chk_out("t5.g2", 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1);
        @(negedge clk);
        chk_out("t5.gap", 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
        @(negedge clk); req_valid = 1'b0;
        chk_out("t5.g1", 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0);
        @(negedge clk);
        chk_out("t5.g0", 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1);
        chk("t5.zero_sticky", 32'(zero_req), 32'd1);
        @(negedge clk);

        // Scenario 4: asynchronous reset in the middle of a 1111 batch.
        req_valid = 1'b1; req = 4'b1111; gnt_ready = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        chk_out("t4.g3", 1'b0, 1'b1, 4'b1000, 2'd3, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk_out("t4.async", 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
        chk("t4.zero_clr", 32'(zero_req), 32'd0);
        @(negedge clk); reset = 1'b0;
        req_valid = 1'b1; req = 4'b0001;
        @(negedge clk); req_valid = 1'b0;
        chk_out("t4.single", 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1);
        @(negedge clk);
        chk_out("t4.idle", 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);

        // Randomized phase against the model, with occasional async reset pulses.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req_valid = ($urandom_range(0, 9) < 6);
            req       = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            gnt_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
